// File: rtl/uart_tx_shift_engine_pkg.sv
// Shared types, sizes and the frame builder for the UART transmit shift engine.
package uart_tx_shift_engine_pkg;

  localparam int unsigned BAUD_W     = 20;
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned BITCNT_W   = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0]        data;
    logic              eight;
    logic              pen;
    logic              ohel;
    logic [BAUD_W-1:0] baud_k;
  } tx_req_t;

  // Frame bit 0 is the start bit and goes out first; unused trailing slots idle high.
  function automatic logic [FRAME_BITS-1:0] build_frame(input tx_req_t r);
    logic p;
    p = (r.eight ? (^r.data) : (^r.data[6:0])) ^ r.ohel;
    case ({r.eight, r.pen})
      2'b11:   build_frame = {1'b1, p, r.data, 1'b0};
      2'b10:   build_frame = {2'b11, r.data, 1'b0};
      2'b01:   build_frame = {2'b11, p, r.data[6:0], 1'b0};
      default: build_frame = {3'b111, r.data[6:0], 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_shift_engine_if.sv
// Request/status bundle between the transmit load register and the shift engine.
interface uart_tx_shift_engine_if;
  import uart_tx_shift_engine_pkg::*;

  logic    start;
  tx_req_t req;
  logic    tx;
  logic    tx_rdy;
  logic    busy;

  modport master (output start, req, input tx, tx_rdy, busy);
  modport slave  (input start, req, output tx, tx_rdy, busy);
endinterface

// File: rtl/uart_tx_shift_engine_baud_counter.sv
// Bit-time counter: counts 0..k-1 while enabled, flags the last cycle of each bit.
module uart_baud_counter
  import uart_tx_shift_engine_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [BAUD_W-1:0] k,
  output logic              tc_c
);

  logic [BAUD_W-1:0] cnt_q;

  assign tc_c = en && (cnt_q == (k - BAUD_W'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc_c ? '0 : cnt_q + BAUD_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_shift_engine.sv
// UART transmit back end: frames the loaded byte and shifts it out LSB-first on tx.
module uart_tx_shift_engine
  import uart_tx_shift_engine_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  uart_tx_shift_engine_if.slave  bus
);

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] sreg_q, sreg_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [BAUD_W-1:0]     k_q, k_d;
  logic                  tx_q, tx_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic [FRAME_BITS-1:0] frame_c;
  logic                  load_c;
  logic                  tc_c;

  uart_baud_counter u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (load_c),
    .en    (state_q == S_SEND),
    .k     (k_q),
    .tc_c  (tc_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sreg_q   <= '1;
      bitcnt_q <= '0;
      k_q      <= BAUD_W'(1);
      tx_q     <= 1'b1;
      rdy_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      bitcnt_q <= bitcnt_d;
      k_q      <= k_d;
      tx_q     <= tx_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  // tx is loaded with the next line value alongside the shift so it never lags a bit.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bitcnt_d = bitcnt_q;
    k_d      = k_q;
    tx_d     = tx_q;
    rdy_d    = rdy_q;
    busy_d   = busy_q;
    load_c   = 1'b0;
    frame_c  = build_frame(bus.req);

    if (state_q == S_IDLE) begin
      if (bus.start) begin
        load_c   = 1'b1;
        sreg_d   = frame_c;
        tx_d     = frame_c[0];
        bitcnt_d = '0;
        k_d      = (bus.req.baud_k == '0) ? BAUD_W'(1) : bus.req.baud_k;
        state_d  = S_SEND;
        rdy_d    = 1'b0;
        busy_d   = 1'b1;
      end
    end else if (tc_c) begin
      if (bitcnt_q == BITCNT_W'(FRAME_BITS - 1)) begin
        state_d  = S_IDLE;
        sreg_d   = '1;
        bitcnt_d = '0;
        tx_d     = 1'b1;
        rdy_d    = 1'b1;
        busy_d   = 1'b0;
      end else begin
        sreg_d   = {1'b1, sreg_q[FRAME_BITS-1:1]};
        tx_d     = sreg_q[1];
        bitcnt_d = bitcnt_q + BITCNT_W'(1);
      end
    end
  end

  assign bus.tx     = tx_q;
  assign bus.tx_rdy = rdy_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_shift_engine.sv
// Directed bench for uart_tx_shift_engine: frame contents, bit timing, start handling, reset.
module tb_uart_tx_shift_engine;
  import uart_tx_shift_engine_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_shift_engine_if bus();

  uart_tx_shift_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [7:0] d, input logic e, input logic p,
                         input logic o, input int k);
    bus.req.data   = d;
    bus.req.eight  = e;
    bus.req.pen    = p;
    bus.req.ohel   = o;
    bus.req.baud_k = 20'(k);
  endtask

  // Called at a negedge with the engine idle; inj >= 0 pulses a foreign start mid-frame.
  task automatic run_frame(input string name, input logic [7:0] d, input logic e,
                           input logic p, input logic o, input int k,
                           input logic [10:0] exp, input int inj);
    int kexp;
    kexp = (k == 0) ? 1 : k;
    set_req(d, e, p, o, k);
    bus.start = 1'b1;
    for (int c = 0; c < 11 * kexp; c++) begin
      @(negedge clk);
      bus.start = (c == inj);
      if (c == inj) set_req(8'hC3, 1'b0, 1'b1, 1'b1, 1);
      check_eq($sformatf("%s_c%0d_tx", name, c), 32'(bus.tx), 32'(exp[c / kexp]));
      check_eq($sformatf("%s_c%0d_rdy", name, c), 32'(bus.tx_rdy), 32'(1'b0));
      check_eq($sformatf("%s_c%0d_busy", name, c), 32'(bus.busy), 32'(1'b1));
    end
    @(negedge clk);
    bus.start = 1'b0;
    check_eq({name, "_end_tx"}, 32'(bus.tx), 32'(1'b1));
    check_eq({name, "_end_rdy"}, 32'(bus.tx_rdy), 32'(1'b1));
    check_eq({name, "_end_busy"}, 32'(bus.busy), 32'(1'b0));
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    set_req(8'h00, 1'b1, 1'b0, 1'b0, 1);
    #2;
    check_eq("rst_tx", 32'(bus.tx), 32'(1'b1));
    check_eq("rst_rdy", 32'(bus.tx_rdy), 32'(1'b1));
    check_eq("rst_busy", 32'(bus.busy), 32'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 8N1-style frame, 4 clocks per bit: 0,1,0,1,0,0,1,0,1,1,1
    run_frame("a5_k4", 8'hA5, 1'b1, 1'b0, 1'b0, 4, 11'h74A, -1);
    // three ones: even parity bit 1, odd parity bit 0
    run_frame("07_even", 8'h07, 1'b1, 1'b1, 1'b0, 3, 11'h60E, -1);
    run_frame("07_odd", 8'h07, 1'b1, 1'b1, 1'b1, 3, 11'h40E, -1);
    // 7-bit mode ignores d7: seven ones, odd parity 0 in slot 8
    run_frame("ff_7o", 8'hFF, 1'b0, 1'b1, 1'b1, 2, 11'h6FE, -1);
    // foreign start at cycle 5 is ignored; next frames start in the first idle cycle
    run_frame("3c_inj", 8'h3C, 1'b1, 1'b0, 1'b0, 5, 11'h678, 5);
    run_frame("5a_k0", 8'h5A, 1'b1, 1'b1, 1'b0, 0, 11'h4B4, -1);
    run_frame("5a_k1", 8'h5A, 1'b1, 1'b1, 1'b0, 1, 11'h4B4, -1);

    // reset in the middle of the start bit
    set_req(8'h00, 1'b1, 1'b0, 1'b0, 8);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_tx", 32'(bus.tx), 32'(1'b0));
    check_eq("mid_busy", 32'(bus.busy), 32'(1'b1));
    reset = 1'b1;
    #1;
    check_eq("arst_tx", 32'(bus.tx), 32'(1'b1));
    check_eq("arst_rdy", 32'(bus.tx_rdy), 32'(1'b1));
    check_eq("arst_busy", 32'(bus.busy), 32'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_idle_tx", 32'(bus.tx), 32'(1'b1));
    check_eq("post_idle_rdy", 32'(bus.tx_rdy), 32'(1'b1));
    run_frame("81_k2", 8'h81, 1'b1, 1'b0, 1'b0, 2, 11'h702, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
